// File: rtl/life_pkg.sv
// Shared constants, state/opcode types and the edit-op helper for the
// 16x16 Game-of-Life sequencer.
package life_pkg;

  localparam int BOARD_SIDE = 16;
  localparam int CELLS      = BOARD_SIDE * BOARD_SIDE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    SWAP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'b00,
    OP_SET    = 2'b01,
    OP_CLR    = 2'b10,
    OP_NOP    = 2'b11
  } edit_op_t;

  // Neighbour offsets in 4-bit two's complement; the 4-bit add gives the torus wrap.
  localparam logic [3:0] NB_DX [8] = '{4'hF, 4'h0, 4'h1, 4'hF, 4'h1, 4'hF, 4'h0, 4'h1};
  localparam logic [3:0] NB_DY [8] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};

  function automatic logic apply_op(input logic old_cell, input logic [1:0] op);
    case (op)
      OP_TOGGLE: return ~old_cell;
      OP_SET:    return 1'b1;
      OP_CLR:    return 1'b0;
      default:   return old_cell;
    endcase
  endfunction

endpackage

// File: rtl/life_rule.sv
// Conway rule for one cell: counts the eight neighbours and produces the
// cell's next state (birth on 3, survival on 2 or 3).
module life_rule (
  input  logic [7:0] i_nbrs,
  input  logic       i_centre,
  output logic       o_next,
  output logic [3:0] o_count
);

  always_comb begin
    o_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_nbrs[i]};
    end
    o_next = (o_count == 4'd3) | (i_centre & (o_count == 4'd2));
  end

endmodule

// File: rtl/life_gen_sequencer.sv
// Double-banked 16x16 Game-of-Life board: sweeps one cell per cycle into the
// next bank on each step tick, then swaps; arbitrates cursor edits and wipes.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int GEN_W      = 16,
  parameter int BOARD_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_in,
  input  logic                  run_en,
  input  logic                  edit_req,
  input  logic [BOARD_LOG2-1:0] edit_x,
  input  logic [BOARD_LOG2-1:0] edit_y,
  input  logic [1:0]            edit_op,
  input  logic                  clear_req,
  input  logic [BOARD_LOG2-1:0] rd_x,
  input  logic [BOARD_LOG2-1:0] rd_y,
  output logic                  rd_cell,
  output logic                  busy,
  output logic [GEN_W-1:0]      gen_count,
  output logic [8:0]            pop_count,
  output logic                  edit_ack,
  output logic                  tick_missed
);

  localparam int IDX_W = 2 * BOARD_LOG2;

  state_t                r_state;
  state_t                w_state_next;
  logic [CELLS-1:0]      r_cur;
  logic [CELLS-1:0]      r_next;
  logic [IDX_W-1:0]      r_idx;
  logic [8:0]            r_acc;
  logic [8:0]            r_pop;
  logic [GEN_W-1:0]      r_gen;
  logic                  r_step_prev;
  logic                  r_edit_ack;
  logic                  r_tick_missed;
  logic                  r_pend_valid;
  logic [BOARD_LOG2-1:0] r_pend_x;
  logic [BOARD_LOG2-1:0] r_pend_y;
  logic [1:0]            r_pend_op;

  logic                  w_busy;
  logic                  w_tick;
  logic                  w_edit_fire;
  logic [BOARD_LOG2-1:0] w_ed_x;
  logic [BOARD_LOG2-1:0] w_ed_y;
  logic [1:0]            w_ed_op;
  logic [IDX_W-1:0]      w_ed_addr;
  logic                  w_ed_old;
  logic                  w_ed_new;
  logic [BOARD_LOG2-1:0] w_cx;
  logic [BOARD_LOG2-1:0] w_cy;
  logic [7:0]            w_nbrs;
  logic                  w_rule_next;
  logic [3:0]            w_nbr_count;

  assign w_busy = (r_state == SWEEP) || (r_state == SWAP);
  assign w_tick = step_in & ~r_step_prev & run_en;

  // A held edit takes precedence over a fresh request in the same IDLE cycle.
  assign w_edit_fire = (r_state == IDLE) & ~clear_req & (r_pend_valid | edit_req);
  assign w_ed_x      = r_pend_valid ? r_pend_x  : edit_x;
  assign w_ed_y      = r_pend_valid ? r_pend_y  : edit_y;
  assign w_ed_op     = r_pend_valid ? r_pend_op : edit_op;
  assign w_ed_addr   = {w_ed_y, w_ed_x};
  assign w_ed_old    = r_cur[w_ed_addr];
  assign w_ed_new    = apply_op(w_ed_old, w_ed_op);

  assign w_cx = r_idx[BOARD_LOG2-1:0];
  assign w_cy = r_idx[IDX_W-1:BOARD_LOG2];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nbr
      logic [BOARD_LOG2-1:0] w_nx;
      logic [BOARD_LOG2-1:0] w_ny;
      assign w_nx       = w_cx + NB_DX[gi];
      assign w_ny       = w_cy + NB_DY[gi];
      assign w_nbrs[gi] = r_cur[{w_ny, w_nx}];
    end
  endgenerate

  life_rule u_rule (
    .i_nbrs   (w_nbrs),
    .i_centre (r_cur[r_idx]),
    .o_next   (w_rule_next),
    .o_count  (w_nbr_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear_req) begin
      w_state_next = CLEAR;
    end else begin
      case (r_state)
        IDLE:    if (w_tick) w_state_next = SWEEP;
        SWEEP:   if (&r_idx) w_state_next = SWAP;
        SWAP:    w_state_next = IDLE;
        CLEAR:   w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur         <= '0;
      r_next        <= '0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_pop         <= '0;
      r_gen         <= '0;
      r_step_prev   <= 1'b0;
      r_edit_ack    <= 1'b0;
      r_tick_missed <= 1'b0;
    end else begin
      r_step_prev   <= step_in;
      r_edit_ack    <= 1'b0;
      r_tick_missed <= w_tick & w_busy;
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          r_acc <= '0;
          if (w_edit_fire) begin
            r_cur[w_ed_addr] <= w_ed_new;
            r_pop            <= r_pop + {8'd0, w_ed_new} - {8'd0, w_ed_old};
            r_edit_ack       <= 1'b1;
          end
        end
        SWEEP: begin
          r_next[r_idx] <= w_rule_next;
          r_acc         <= r_acc + {8'd0, w_rule_next};
          r_idx         <= r_idx + 1'b1;
        end
        SWAP: begin
          if (!clear_req) begin
            r_cur <= r_next;
            r_gen <= r_gen + 1'b1;
            r_pop <= r_acc;
          end
        end
        CLEAR: begin
          r_cur  <= '0;
          r_next <= '0;
          r_gen  <= '0;
          r_pop  <= '0;
        end
        default: ;
      endcase
    end
  end

  // One-entry edit holding slot: the newest request overwrites, a wipe discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_x     <= '0;
      r_pend_y     <= '0;
      r_pend_op    <= '0;
    end else if (clear_req || (r_state == CLEAR)) begin
      r_pend_valid <= 1'b0;
    end else if (edit_req && (w_busy || ((r_state == IDLE) && r_pend_valid))) begin
      r_pend_valid <= 1'b1;
      r_pend_x     <= edit_x;
      r_pend_y     <= edit_y;
      r_pend_op    <= edit_op;
    end else if (r_state == IDLE) begin
      r_pend_valid <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
                   (r_state == SWEEP) |-> (w_nbr_count <= 4'd8));

  assign rd_cell     = r_cur[{rd_y, rd_x}];
  assign busy        = w_busy;
  assign gen_count   = r_gen;
  assign pop_count   = r_pop;
  assign edit_ack    = r_edit_ack;
  assign tick_missed = r_tick_missed;

endmodule
